// File: rtl/elevator_pkg.sv
// Shared types for the elevator car controller: FSM states and travel direction.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVING    = 2'd1,
    DOOR_OPEN = 2'd2,
    SOS       = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/floor_request_queue.sv
// Pending floor-call set plus the SCAN look-ahead detectors relative to the car position.
import elevator_pkg::*;

module floor_request_queue #(
  parameter int FLOORS = 8,
  parameter int FW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] set_mask,
  input  logic              clr_en,
  input  logic [FW-1:0]     clr_floor,
  input  logic              flush,
  input  logic [FW-1:0]     cur_floor,
  input  logic              dir,
  output logic [FLOORS-1:0] pending,
  output logic              ahead,
  output logic              behind
);

  logic [FLOORS-1:0] pending_r;
  logic [FLOORS-1:0] pending_s;
  logic [FLOORS-1:0] clr_mask_s;
  logic              above_s;
  logic              below_s;

  // Next pending set: a same-edge clear wins over a new call, flush wins over all.
  always_comb begin
    clr_mask_s = '0;
    if (clr_en) begin
      clr_mask_s[clr_floor] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
    if (flush) begin
      pending_s = '0;
    end else begin
      pending_s = (pending_r | set_mask) & ~clr_mask_s;
    end
  end

  // Pending register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r <= '0;
    end else begin
      pending_r <= pending_s;
    end
  end

  // Any latched call strictly above / strictly below the car.
  always_comb begin
    above_s = 1'b0;
    below_s = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      above_s = above_s | (pending_r[i] & (FW'(i) > cur_floor));
      below_s = below_s | (pending_r[i] & (FW'(i) < cur_floor));
    end
  end

  assign ahead   = (dir == DIR_UP) ? above_s : below_s;
  assign behind  = (dir == DIR_UP) ? below_s : above_s;
  assign pending = pending_r;

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN car-motion controller: latches calls, sequences travel and door dwell, halts on SOS.
import elevator_pkg::*;

module elevator_scheduler #(
  parameter  int FLOORS      = 8,
  parameter  int MOVE_CYCLES = 3,
  parameter  int DOOR_CYCLES = 4,
  localparam int FW          = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] floor_request,
  input  logic              sos_mode,
  output logic [FW-1:0]     current_floor,
  output logic              moving_up,
  output logic              moving_down,
  output logic              door_open,
  output logic [FLOORS-1:0] pending
);

  localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  state_t            state_r, state_s;
  logic              dir_r, dir_s;
  logic [FW-1:0]     cur_r, cur_s, next_floor_s;
  logic [MW-1:0]     move_cnt_r, move_cnt_s;
  logic [DW-1:0]     door_cnt_r, door_cnt_s;
  logic [FLOORS-1:0] set_mask_s;
  logic              clr_en_s;
  logic [FW-1:0]     clr_floor_s;
  logic              flush_s;
  logic              ahead_s, behind_s;
  logic [FLOORS-1:0] pending_s;

  floor_request_queue #(.FLOORS(FLOORS), .FW(FW)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .set_mask (set_mask_s),
    .clr_en   (clr_en_s),
    .clr_floor(clr_floor_s),
    .flush    (flush_s),
    .cur_floor(cur_r),
    .dir      (dir_r),
    .pending  (pending_s),
    .ahead    (ahead_s),
    .behind   (behind_s)
  );

  assign next_floor_s = (dir_r == DIR_UP) ? cur_r + FW'(1) : cur_r - FW'(1);

  // Next-state, counter and queue-control decode.
  always_comb begin
    state_s     = state_r;
    dir_s       = dir_r;
    cur_s       = cur_r;
    move_cnt_s  = move_cnt_r;
    door_cnt_s  = door_cnt_r;
    set_mask_s  = floor_request;
    clr_en_s    = 1'b0;
    clr_floor_s = cur_r;
    flush_s     = 1'b0;
    if (sos_mode) begin
      state_s    = SOS;
      flush_s    = 1'b1;
      set_mask_s = '0;
      move_cnt_s = '0;
      door_cnt_s = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pending_s[cur_r]) begin
            clr_en_s   = 1'b1;
            state_s    = DOOR_OPEN;
            door_cnt_s = '0;
          end else if (ahead_s) begin
            state_s    = MOVING;
            move_cnt_s = '0;
          end else if (behind_s) begin
            dir_s      = (dir_r == DIR_UP) ? DIR_DOWN : DIR_UP;
            state_s    = MOVING;
            move_cnt_s = '0;
          end else begin
            state_s = IDLE;
          end
        end
        MOVING: begin
          if (move_cnt_r == MW'(MOVE_CYCLES - 1)) begin
            move_cnt_s = '0;
            cur_s      = next_floor_s;
            if (pending_s[next_floor_s]) begin
              clr_en_s    = 1'b1;
              clr_floor_s = next_floor_s;
              state_s     = DOOR_OPEN;
              door_cnt_s  = '0;
            end else begin
              state_s = MOVING;
            end
          end else begin
            move_cnt_s = move_cnt_r + MW'(1);
          end
        end
        DOOR_OPEN: begin
          // A call for the floor being served extends the dwell instead of queueing.
          set_mask_s[cur_r] = 1'b0;
          if (floor_request[cur_r]) begin
            door_cnt_s = '0;
          end else if (door_cnt_r == DW'(DOOR_CYCLES - 1)) begin
            door_cnt_s = '0;
            move_cnt_s = '0;
            if (ahead_s) begin
              state_s = MOVING;
            end else if (behind_s) begin
              dir_s   = (dir_r == DIR_UP) ? DIR_DOWN : DIR_UP;
              state_s = MOVING;
            end else begin
              state_s = IDLE;
            end
          end else begin
            door_cnt_s = door_cnt_r + DW'(1);
          end
        end
        SOS: begin
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // FSM, direction, position and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      dir_r      <= DIR_UP;
      cur_r      <= '0;
      move_cnt_r <= '0;
      door_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      dir_r      <= dir_s;
      cur_r      <= cur_s;
      move_cnt_r <= move_cnt_s;
      door_cnt_r <= door_cnt_s;
    end
  end

  assign current_floor = cur_r;
  assign moving_up     = (state_r == MOVING) && (dir_r == DIR_UP);
  assign moving_down   = (state_r == MOVING) && (dir_r == DIR_DOWN);
  assign door_open     = (state_r == DOOR_OPEN);
  assign pending       = pending_s;

endmodule
